// File: rtl/safe_pkg.sv
// Shared types and constants for the keypad safe controller.
package safe_pkg;

    // Controller states; the encoding is visible on the `state` output.
    typedef enum logic [2:0] {
        S_OFF    = 3'b000,
        S_ON     = 3'b001,
        S_WRONG1 = 3'b010,
        S_WRONG2 = 3'b011,
        S_OPEN   = 3'b100,
        S_RESET  = 3'b101,
        S_LOCK   = 3'b111
    } state_t;

    localparam logic [3:0] KEY_STAR   = 4'hA;
    localparam logic [3:0] KEY_HASH   = 4'hB;
    localparam int         MAX_DIGITS = 6;

    // Key index is row*3 + col, rows/cols counted from 0.
    function automatic logic [3:0] key_code_of(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd9:    code = KEY_STAR;
            4'd10:   code = 4'h0;
            4'd11:   code = KEY_HASH;
            default: code = idx + 4'd1;
        endcase
        return code;
    endfunction

    // Thermometer bar of the digit count, filled from bit 5 downward.
    function automatic logic [5:0] led_bar(input logic [2:0] n);
        return ~(6'h3F >> n);
    endfunction

endpackage

// File: rtl/safe_keypad_debounce.sv
// Keypad front end: input synchronizers, per-key debounce and key event encoding.
module keypad_debounce
    import safe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    input  logic [2:0] cols,
    input  logic       pw_btn,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       pw_req
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    row_s1, row_s2;
    logic [2:0]    col_s1, col_s2;
    logic          pw_s1, pw_s2, pw_d;
    logic [11:0]   deb;
    logic [CW-1:0] cnt [12];
    logic [11:0]   adv;
    logic [11:0]   rise;
    logic [3:0]    rise_idx;

    // Two-flop synchronizers for all asynchronous pad inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= '0;
            row_s2 <= '0;
            col_s1 <= '0;
            col_s2 <= '0;
            pw_s1  <= 1'b0;
            pw_s2  <= 1'b0;
        end else begin
            row_s1 <= rows;
            row_s2 <= row_s1;
            col_s1 <= cols;
            col_s2 <= col_s1;
            pw_s1  <= pw_btn;
            pw_s2  <= pw_s1;
        end
    end

    // A key's counter advances only while its row is strobed and its column disagrees with the debounced bit.
    always_comb begin
        adv      = '0;
        rise     = '0;
        rise_idx = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                adv[r*3+c]  = row_s2[r] && (col_s2[c] != deb[r*3+c]);
                rise[r*3+c] = adv[r*3+c] && (cnt[r*3+c] == CNT_LAST) && !deb[r*3+c];
            end
        end
        for (int unsigned k = 0; k < 12; k++) begin
            if (rise[k]) rise_idx = 4'(k);
        end
    end

    // Debounce counters; the debounced bit toggles when a counter completes its run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int unsigned k = 0; k < 12; k++) cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < 12; k++) begin
                if (adv[k]) begin
                    if (cnt[k] == CNT_LAST) begin
                        cnt[k] <= '0;
                        deb[k] <= ~deb[k];
                    end else begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    // One-cycle key event on a single press edge; simultaneous presses are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            pw_d      <= 1'b0;
            pw_req    <= 1'b0;
        end else begin
            key_valid <= ($countones(rise) == 1);
            key_code  <= key_code_of(rise_idx);
            pw_d      <= pw_s2;
            pw_req    <= pw_s2 & ~pw_d;
        end
    end

endmodule

// File: rtl/safe.sv
// Digital safe controller: entry buffer, password store and attempt-limited unlock FSM.
module safe
    import safe_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1000,
    parameter logic [23:0] DEFAULT_PW      = 24'h001234,
    parameter int          DEFAULT_LEN     = 4
) (
    input  logic       clk,
    input  logic       initialize,
    input  logic       row1,
    input  logic       row2,
    input  logic       row3,
    input  logic       row4,
    input  logic       col1,
    input  logic       col2,
    input  logic       col3,
    input  logic       reset_password,
    output logic [5:0] password_led,
    output logic [2:0] state
);

    localparam logic [2:0] DEF_LEN = 3'(DEFAULT_LEN);
    localparam logic [2:0] MAX_LEN = 3'(MAX_DIGITS);

    logic        key_valid;
    logic [3:0]  key_code;
    logic        pw_req;
    state_t      st;
    logic [23:0] entry;
    logic [2:0]  entry_len;
    logic [23:0] password;
    logic [2:0]  pw_len;
    logic        match;

    keypad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_keypad (
        .clk      (clk),
        .rst_n    (initialize),
        .rows     ({row4, row3, row2, row1}),
        .cols     ({col3, col2, col1}),
        .pw_btn   (reset_password),
        .key_valid(key_valid),
        .key_code (key_code),
        .pw_req   (pw_req)
    );

    assign state = st;
    assign match = (entry_len == pw_len) && (entry == password);

    // Controller FSM with entry buffer, password store and registered LED bar.
    always_ff @(posedge clk or negedge initialize) begin
        if (!initialize) begin
            st           <= S_OFF;
            entry        <= '0;
            entry_len    <= '0;
            password     <= DEFAULT_PW;
            pw_len       <= DEF_LEN;
            password_led <= '0;
        end else begin
            case (st)
                S_OFF: begin
                    if (key_valid && key_code == KEY_STAR) begin
                        st           <= S_ON;
                        entry        <= '0;
                        entry_len    <= '0;
                        password_led <= '0;
                    end
                end
                S_ON, S_WRONG1, S_WRONG2, S_RESET: begin
                    if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (entry_len < MAX_LEN) begin
                                entry        <= {entry[19:0], key_code};
                                entry_len    <= entry_len + 3'd1;
                                password_led <= led_bar(entry_len + 3'd1);
                            end
                        end else if (key_code == KEY_STAR) begin
                            entry        <= '0;
                            entry_len    <= '0;
                            password_led <= '0;
                        end else if (key_code == KEY_HASH) begin
                            if (st == S_RESET) begin
                                if (entry_len != 3'd0) begin
                                    password     <= entry;
                                    pw_len       <= entry_len;
                                    st           <= S_OFF;
                                    entry        <= '0;
                                    entry_len    <= '0;
                                    password_led <= '0;
                                end
                            end else begin
                                entry        <= '0;
                                entry_len    <= '0;
                                password_led <= '0;
                                if (match)              st <= S_OPEN;
                                else if (st == S_ON)    st <= S_WRONG1;
                                else if (st == S_WRONG1) st <= S_WRONG2;
                                else                    st <= S_LOCK;
                            end
                        end
                    end
                end
                S_OPEN: begin
                    if (pw_req) begin
                        st           <= S_RESET;
                        entry        <= '0;
                        entry_len    <= '0;
                        password_led <= '0;
                    end else if (key_valid && key_code == KEY_HASH) begin
                        st           <= S_OFF;
                        password_led <= '0;
                    end
                end
                S_LOCK: begin
                    password_led <= '0;
                end
                default: begin
                    st           <= S_OFF;
                    password_led <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safe.sv
// Randomized scoreboard bench for the safe controller with a queue-based reference model.
module tb_safe;

    localparam int DWELL  = 5;
    localparam int PERIOD = 4 * DWELL;

    logic       clk = 1'b0;
    logic       initialize;
    logic [3:0] rows;
    logic [2:0] cols;
    logic       reset_password;
    logic [5:0] password_led;
    logic [2:0] state;

    int  pk_row = 0, pk_col = 0, gl_row = 0, gl_col = 0;
    logic pk_on = 1'b0, gl_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;
    logic [8:0] sb[$];

    // Reference model state (abstract: digit lists and tries count).
    int m_mode;   // 0 off, 1 entering, 2 open, 3 new password, 4 locked
    int m_tries;
    int m_entry[$];
    int m_pw[$];
    logic [8:0] m_last;

    always #5 clk = ~clk;

    safe #(
        .DEBOUNCE_CYCLES(2),
        .DEFAULT_PW     (24'h001234),
        .DEFAULT_LEN    (4)
    ) dut (
        .clk           (clk),
        .initialize    (initialize),
        .row1          (rows[0]),
        .row2          (rows[1]),
        .row3          (rows[2]),
        .row4          (rows[3]),
        .col1          (cols[0]),
        .col2          (cols[1]),
        .col3          (cols[2]),
        .reset_password(reset_password),
        .password_led  (password_led),
        .state         (state)
    );

    always_comb begin
        cols = '0;
        if (pk_on && rows[pk_row]) cols[pk_col] = 1'b1;
        if (gl_on && rows[gl_row]) cols[gl_col] = 1'b1;
    end

    initial begin
        rows = 4'b0001;
        forever begin
            repeat (DWELL) @(posedge clk);
            #1 rows = {rows[2:0], rows[3]};
        end
    end

    function automatic logic [8:0] m_out();
        logic [5:0] led;
        logic [2:0] s;
        led = '0;
        for (int i = 0; i < m_entry.size(); i++) led[5-i] = 1'b1;
        case (m_mode)
            1: s = (m_tries == 3) ? 3'd1 : (m_tries == 2) ? 3'd2 : 3'd3;
            2: s = 3'd4;
            3: s = 3'd5;
            4: s = 3'd7;
            default: s = 3'd0;
        endcase
        if (m_mode == 0 || m_mode == 2 || m_mode == 4) led = '0;
        return {s, led};
    endfunction

    task automatic m_note();
        logic [8:0] o;
        o = m_out();
        if (o != m_last) sb.push_back(o);
        m_last = o;
    endtask

    task automatic m_key(input int code);
        logic same;
        case (m_mode)
            0: if (code == 10) begin m_mode = 1; m_tries = 3; m_entry.delete(); end
            1, 3: begin
                if (code <= 9) begin
                    if (m_entry.size() < 6) m_entry.push_back(code);
                end else if (code == 10) begin
                    m_entry.delete();
                end else if (m_mode == 3) begin
                    if (m_entry.size() > 0) begin
                        m_pw = m_entry;
                        m_entry.delete();
                        m_mode = 0;
                    end
                end else begin
                    same = (m_entry.size() == m_pw.size());
                    for (int i = 0; i < m_entry.size() && same; i++)
                        if (m_entry[i] != m_pw[i]) same = 1'b0;
                    m_entry.delete();
                    if (same) m_mode = 2;
                    else begin
                        m_tries--;
                        if (m_tries == 0) m_mode = 4;
                    end
                end
            end
            2: if (code == 11) m_mode = 0;
            default: ;
        endcase
        m_note();
    endtask

    task automatic m_init();
        m_mode = 0;
        m_tries = 3;
        m_entry.delete();
        m_pw = '{1, 2, 3, 4};
        m_note();
    endtask

    task automatic press(input int code, input int periods);
        if (code >= 1 && code <= 9) begin pk_row = (code - 1) / 3; pk_col = (code - 1) % 3; end
        else if (code == 0)         begin pk_row = 3; pk_col = 1; end
        else if (code == 10)        begin pk_row = 3; pk_col = 0; end
        else                        begin pk_row = 3; pk_col = 2; end
        m_key(code);
        pk_on = 1'b1;
        repeat (periods * PERIOD) @(posedge clk);
        #1 pk_on = 1'b0;
        repeat (2 * PERIOD) @(posedge clk);
        #1;
    endtask

    task automatic pw_pulse();
        if (m_mode == 2) begin m_mode = 3; m_entry.delete(); end
        m_note();
        reset_password = 1'b1;
        repeat (8) @(posedge clk);
        #1 reset_password = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        @(posedge clk);
        #2 initialize = 1'b0;
        m_init();
        #1;
        n_cmp++;
        if (state !== 3'd0 || password_led !== 6'd0) begin
            n_bad++;
            $display("FAIL async_init: state=%b led=%b, required state=000 led=000000", state, password_led);
        end
        repeat (3) @(posedge clk);
        #1 initialize = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic seq(input int codes[$]);
        foreach (codes[i]) press(codes[i], 2);
    endtask

    // Monitor: every change of the DUT outputs must match the next scoreboard entry.
    initial begin
        logic [8:0] prev, cur, e;
        wait (mon_en);
        prev = {state, password_led};
        forever begin
            @(negedge clk);
            cur = {state, password_led};
            if (cur !== prev) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: state=%b led=%b, required unchanged state=%b led=%b",
                             cur[8:6], cur[5:0], prev[8:6], prev[5:0]);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL output_step: state=%b led=%b, required state=%b led=%b",
                                 cur[8:6], cur[5:0], e[8:6], e[5:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int r, code;
        initialize = 1'b0;
        reset_password = 1'b0;
        m_last = '0;
        m_init();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (state !== 3'd0 || password_led !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_state: state=%b led=%b, required state=000 led=000000", state, password_led);
        end
        initialize = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Unlock with the default password.
        seq('{10, 1, 2, 3, 4, 11});
        // Three wrong attempts lead to lockout; further keys do nothing.
        press(11, 2);
        seq('{10, 1, 2, 3, 11, 1, 2, 3, 11, 1, 2, 3, 11});
        seq('{1, 10, 11, 5});
        pw_pulse();
        do_init();
        // Change the password from OPEN, then check old and new.
        seq('{10, 1, 2, 3, 4, 11});
        pw_pulse();
        seq('{9, 8, 11});
        seq('{10, 1, 2, 3, 4, 11});
        seq('{10, 9, 8, 11});
        // Six-digit password; a seventh digit is dropped.
        pw_pulse();
        seq('{11, 1, 2, 3, 4, 5, 6, 11});
        seq('{10, 1, 2, 3, 4, 5, 6, 7, 11});
        // Held key gives one event; a short glitch gives none.
        seq('{11, 10});
        press(5, 10);
        @(posedge clk iff rows[1]);
        #1 gl_row = 1; gl_col = 1; gl_on = 1'b1;
        @(posedge clk);
        #1 gl_on = 1'b0;
        repeat (2 * PERIOD) @(posedge clk);
        #1;
        seq('{11, 1, 2});
        do_init();
        seq('{10, 1, 2, 3, 4, 11});

        // Randomized traffic against the model.
        for (int n = 0; n < 90; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5 || (m_mode == 4 && r < 40)) begin
                do_init();
            end else if (r < 14) begin
                pw_pulse();
            end else if (r < 28) begin
                press(10, 2);
                foreach (m_pw[i]) press(m_pw[i], 2);
                press(11, 2);
            end else begin
                code = $urandom_range(0, 11);
                press(code, $urandom_range(1, 3));
            end
        end

        repeat (2 * PERIOD) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
